// File: rtl/sync_fifo_status.sv
// ============================================================================
// Module   : sync_fifo_status
// Brief    : Single-clock FIFO with registered read port, occupancy count,
//            almost-full/almost-empty thresholds and synchronous flush.
//            Optional sticky overflow/underflow flags: FIFO_ERR_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_status #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     write_en,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     read_en,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int                c_ADDR_W = $clog2(DEPTH);
    localparam int                c_PTR_W  = c_ADDR_W + 1;
    localparam logic [c_PTR_W-1:0] c_AF    = c_PTR_W'(AF_LEVEL);
    localparam logic [c_PTR_W-1:0] c_AE    = c_PTR_W'(AE_LEVEL);
    localparam logic [c_PTR_W-1:0] c_ONE   = c_PTR_W'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [WIDTH-1:0]   r_data_out;
    logic               r_data_valid;

    logic               w_full;
    logic               w_empty;
    logic [c_PTR_W-1:0] w_count;
    logic               w_wr_acc;
    logic               w_rd_acc;

    // Extended pointers: equal low bits with differing wrap bits means full.
    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[c_ADDR_W-1:0] == r_rptr[c_ADDR_W-1:0]) &&
                      (r_wptr[c_ADDR_W] != r_rptr[c_ADDR_W]);
    assign w_count  = r_wptr - r_rptr;
    assign w_wr_acc = write_en & ~w_full & ~clear;
    assign w_rd_acc = read_en & ~w_empty & ~clear;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr[c_ADDR_W-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else if (clear) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_data_valid <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + c_ONE;
            end
            if (w_rd_acc) begin
                r_rptr     <= r_rptr + c_ONE;
                r_data_out <= r_mem[r_rptr[c_ADDR_W-1:0]];
            end
            r_data_valid <= w_rd_acc;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Flush wins over a same-edge error so the flags always come out clean.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clear) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (write_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (read_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign data_out     = r_data_out;
    assign data_valid   = r_data_valid;
    assign full         = w_full;
    assign empty        = w_empty;
    assign count        = w_count;
    assign almost_full  = (w_count >= c_AF);
    assign almost_empty = (w_count <= c_AE);

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_status.sv
// ============================================================================
// Module   : tb_sync_fifo_status
// Brief    : Scoreboard bench for sync_fifo_status against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_status;

    localparam int c_WIDTH = 16;
    localparam int c_DEPTH = 8;
    localparam int c_AF    = c_DEPTH - 2;
    localparam int c_AE    = 2;

    logic               clk;
    logic               reset_n;
    logic               clear;
    logic               write_en;
    logic [c_WIDTH-1:0] data_in;
    logic               read_en;
    logic [c_WIDTH-1:0] data_out;
    logic               data_valid;
    logic               full;
    logic               empty;
    logic               almost_full;
    logic               almost_empty;
    logic [3:0]         count;
    logic               overflow;
    logic               underflow;

    sync_fifo_status #(
        .WIDTH    (c_WIDTH),
        .DEPTH    (c_DEPTH),
        .AF_LEVEL (c_AF),
        .AE_LEVEL (c_AE)
    ) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .write_en     (write_en),
        .data_in      (data_in),
        .read_en      (read_en),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: FIFO contents as a queue plus the expected read stream.
    logic [c_WIDTH-1:0] m_q [$];
    logic [c_WIDTH-1:0] exp_q [$];
    logic [c_WIDTH-1:0] m_last_out;
    logic               m_valid;
    logic               m_ov;
    logic               m_un;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (reset_n && data_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL read_data: unexpected data_valid, data_out=0x%0h at %0t", data_out, $time);
            end else begin
                chk("read_data", 32'(data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        m_last_out = '0;
        m_valid    = 1'b0;
        m_ov       = 1'b0;
        m_un       = 1'b0;
    endtask

    task automatic model_edge(input logic we, input logic [c_WIDTH-1:0] d,
                              input logic re, input logic cl);
        bit was_full;
        bit was_empty;
        if (cl) begin
            m_q.delete();
            m_valid = 1'b0;
            m_ov    = 1'b0;
            m_un    = 1'b0;
        end else begin
            was_full  = (m_q.size() == c_DEPTH);
            was_empty = (m_q.size() == 0);
            if (we && was_full)  m_ov = 1'b1;
            if (re && was_empty) m_un = 1'b1;
            if (re && !was_empty) begin
                m_last_out = m_q.pop_front();
                exp_q.push_back(m_last_out);
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (we && !was_full) m_q.push_back(d);
        end
    endtask

    task automatic check_status(input string tag);
        int n;
        n = m_q.size();
        chk({tag, ".count"},        32'(count),        32'(n));
        chk({tag, ".empty"},        32'(empty),        32'(n == 0));
        chk({tag, ".full"},         32'(full),         32'(n == c_DEPTH));
        chk({tag, ".almost_full"},  32'(almost_full),  32'(n >= c_AF));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= c_AE));
        chk({tag, ".data_valid"},   32'(data_valid),   32'(m_valid));
        chk({tag, ".data_out"},     32'(data_out),     32'(m_last_out));
`ifdef FIFO_ERR_FLAGS_EN
        chk({tag, ".overflow"},     32'(overflow),     32'(m_ov));
        chk({tag, ".underflow"},    32'(underflow),    32'(m_un));
`else
        chk({tag, ".overflow"},     32'(overflow),     32'(0));
        chk({tag, ".underflow"},    32'(underflow),    32'(0));
`endif
    endtask

    task automatic cycle(input string tag, input logic we, input logic [c_WIDTH-1:0] d,
                         input logic re, input logic cl);
        write_en = we;
        data_in  = d;
        read_en  = re;
        clear    = cl;
        @(posedge clk);
        model_edge(we, d, re, cl);
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
        clear    = 1'b0;
        check_status(tag);
    endtask

    initial begin
        reset_n  = 1'b0;
        clear    = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        data_in  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_status("reset");
        reset_n = 1'b1;
        cycle("idle", 1'b0, '0, 1'b0, 1'b0);

        // Fill with 1..8, then an overflowing write.
        for (int i = 1; i <= c_DEPTH; i++) cycle("fill", 1'b1, 16'(i), 1'b0, 1'b0);
        cycle("overflow_wr", 1'b1, 16'hDEAD, 1'b0, 1'b0);

        // Drain, then an underflowing read that must hold data_out.
        for (int i = 0; i < c_DEPTH; i++) cycle("drain", 1'b0, '0, 1'b1, 1'b0);
        cycle("underflow_rd", 1'b0, '0, 1'b1, 1'b0);

        // Steady-state streaming at count=4 across pointer wraps.
        for (int i = 0; i < 4; i++) cycle("prefill4", 1'b1, 16'($urandom_range(0, 65535)), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle("stream", 1'b1, 16'($urandom_range(0, 65535)), 1'b1, 1'b0);

        // Simultaneous write+read at empty, then at full.
        for (int i = 0; i < 4; i++) cycle("drain4", 1'b0, '0, 1'b1, 1'b0);
        cycle("wr_rd_empty", 1'b1, 16'h1234, 1'b1, 1'b0);
        for (int i = 0; i < c_DEPTH - 1; i++) cycle("refill", 1'b1, 16'($urandom_range(0, 65535)), 1'b0, 1'b0);
        cycle("wr_rd_full", 1'b1, 16'h5678, 1'b1, 1'b0);

        // Clear at count=5 with write and read also asserted.
        cycle("to5_a", 1'b0, '0, 1'b1, 1'b0);
        cycle("to5_b", 1'b0, '0, 1'b1, 1'b0);
        cycle("clear", 1'b1, 16'hBEEF, 1'b1, 1'b1);
        cycle("post_clr_wr", 1'b1, 16'h00AA, 1'b0, 1'b0);
        cycle("post_clr_rd", 1'b0, '0, 1'b1, 1'b0);
        cycle("post_clr_idle", 1'b0, '0, 1'b0, 1'b0);

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 300; i++) begin
            cycle("random", 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0));
        end

        // Asynchronous reset at count=3, between clock edges.
        cycle("pre_rst_clr", 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle("to3", 1'b1, 16'($urandom_range(0, 65535)), 1'b0, 1'b0);
        cycle("to3_idle", 1'b0, '0, 1'b0, 1'b0);
        chk("pre_rst.count", 32'(count), 32'(3));
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_status("async_rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cycle("post_rst", 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
                  1'($urandom_range(0, 1)), 1'b0);
        end
        cycle("final_idle", 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
